// File: rtl/cfu_requant_packer.sv
// cfu_requant_packer
//   Output stage behind the 3x3x4 convolution CFU. It takes signed int32
//   accumulators and requantises each one to int8 in the TFLite style:
//   bias, left shift, rounding doubling high multiply, rounding right shift,
//   output offset and activation clamp. It then packs four int8 results into
//   one 32-bit word.
//
//   Pipeline: S1 (bias + left shift) -> S2 (high multiply) -> S3 (round,
//   offset, clamp) -> pack buffer. A byte lands in the pack buffer 3 cycles
//   after its input transfer. The whole pipeline advances only when
//   in_ready is high.
//
//   Ports
//     clk                   rising-edge clock
//     reset                 asynchronous, active-low
//     cfg_valid/addr/data   config write: 0 bias, 1 multiplier, 2 shift[5:0],
//                           3 out_offset[7:0], 4 act_min[7:0], 5 act_max[7:0],
//                           6 clear saturation counter
//     in_valid/ready/data   int32 accumulator input; in_last flushes a partial word
//     in_last
//     out_valid/ready/data  packed int8 word, byte 0 = oldest element
//     out_bytes             number of valid bytes in out_data (1..4)
//     busy                  any stage, the pack buffer or the output holds data
//     sat_count             clamp-event counter
//
//   Optional feature: define CFU_REQUANT_SAT_STATS_EN to build the saturating
//   clamp-event counter. Without it, sat_count is tied to 0 and writes to
//   address 6 are ignored.
module cfu_requant_packer #(
  parameter int unsigned PACK  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_bytes,
  output logic             busy,
  output logic [CNT_W-1:0] sat_count
);

  typedef enum logic [2:0] {
    CFG_BIAS  = 3'd0,
    CFG_MULT  = 3'd1,
    CFG_SHIFT = 3'd2,
    CFG_OOFF  = 3'd3,
    CFG_AMIN  = 3'd4,
    CFG_AMAX  = 3'd5,
    CFG_CLR   = 3'd6
  } cfg_addr_e;

  // Configuration registers
  logic signed [31:0] r_bias;
  logic signed [31:0] r_mult;
  logic        [5:0]  r_shift;
  logic        [7:0]  r_ooff;
  logic        [7:0]  r_amin;
  logic        [7:0]  r_amax;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bias  <= '0;
      r_mult  <= 32'sh7FFF_FFFF;
      r_shift <= '0;
      r_ooff  <= '0;
      r_amin  <= 8'h80;
      r_amax  <= 8'h7F;
    end else if (cfg_valid) begin
      case (cfg_addr)
        CFG_BIAS:  r_bias  <= cfg_data;
        CFG_MULT:  r_mult  <= cfg_data;
        CFG_SHIFT: r_shift <= cfg_data[5:0];
        CFG_OOFF:  r_ooff  <= cfg_data[7:0];
        CFG_AMIN:  r_amin  <= cfg_data[7:0];
        CFG_AMAX:  r_amax  <= cfg_data[7:0];
        default:   ;
      endcase
    end
  end

  // Global advance
  logic w_en;
  logic r_out_valid;
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // S1: bias and left shift
  logic [4:0]         w_lsh;
  logic [31:0]        w_biased;
  logic [31:0]        w_s1_x;
  logic               r_s1_v, r_s1_last;
  logic signed [31:0] r_s1_x;

  assign w_lsh    = r_shift[5] ? 5'd0 : r_shift[4:0];
  assign w_biased = in_data + r_bias;
  assign w_s1_x   = w_biased << w_lsh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_x    <= '0;
    end else if (w_en) begin
      r_s1_v    <= in_valid;
      r_s1_last <= in_last;
      r_s1_x    <= w_s1_x;
    end
  end

  // S2: saturating rounding doubling high multiply
  logic signed [63:0] w_ab, w_nudge, w_sum, w_sum_adj;
  logic signed [31:0] w_high;
  logic               w_both_min;
  logic               w_unused;
  logic               r_s2_v, r_s2_last;
  logic signed [31:0] r_s2_high;

  assign w_ab       = 64'(r_s1_x) * 64'(r_mult);
  assign w_nudge    = w_ab[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000;
  assign w_sum      = w_ab + w_nudge;
  // Bias negative sums by 2^31-1 so the arithmetic shift truncates toward zero
  assign w_sum_adj  = w_sum[63] ? (w_sum + 64'sh0000_0000_7FFF_FFFF) : w_sum;
  assign w_both_min = (r_s1_x == 32'sh8000_0000) && (r_mult == 32'sh8000_0000);
  assign w_high     = w_both_min ? 32'sh7FFF_FFFF : w_sum_adj[62:31];
  assign w_unused   = ^{w_sum_adj[63], w_sum_adj[30:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_high <= '0;
    end else if (w_en) begin
      r_s2_v    <= r_s1_v;
      r_s2_last <= r_s1_last;
      r_s2_high <= w_high;
    end
  end

  // S3: rounding right shift, offset, clamp
  logic [4:0]         w_r;
  logic [31:0]        w_mask, w_rem, w_thr, w_y;
  logic signed [31:0] w_shr, w_v, w_min, w_max;
  logic               w_gt, w_lo, w_hi, w_clamp_hi;
  logic [7:0]         w_byte;
  logic               r_s3_v, r_s3_last;
  logic [7:0]         r_s3_byte;

  assign w_r    = r_shift[5] ? (~r_shift[4:0] + 5'd1) : 5'd0;
  assign w_mask = (32'd1 << w_r) - 32'd1;
  assign w_rem  = r_s2_high & w_mask;
  assign w_thr  = (w_mask >> 1) + {31'b0, r_s2_high[31]};
  assign w_gt   = w_rem > w_thr;
  assign w_shr  = r_s2_high >>> w_r;
  assign w_y    = w_shr + {31'b0, w_gt};
  assign w_v    = w_y + {{24{r_ooff[7]}}, r_ooff};
  assign w_min  = {{24{r_amin[7]}}, r_amin};
  assign w_max  = {{24{r_amax[7]}}, r_amax};
  assign w_lo   = w_v < w_min;
  assign w_hi   = w_v > w_max;
  // Clamp low first, then high, so an inverted range resolves to act_max
  assign w_clamp_hi = w_lo ? (w_min > w_max) : w_hi;
  assign w_byte     = w_clamp_hi ? r_amax : (w_lo ? r_amin : w_v[7:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s3_v    <= 1'b0;
      r_s3_last <= 1'b0;
      r_s3_byte <= '0;
    end else if (w_en) begin
      r_s3_v    <= r_s2_v;
      r_s3_last <= r_s2_last;
      r_s3_byte <= w_byte;
    end
  end

  // Pack buffer and output word
  logic [31:0] r_pack, w_pack_next;
  logic [1:0]  r_idx;
  logic        w_word_done;
  logic [31:0] r_out_data;
  logic [2:0]  r_out_bytes;

  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[{r_idx, 3'b000} +: 8] = r_s3_byte;
  end

  assign w_word_done = (r_idx == 2'(PACK - 1)) || r_s3_last;

  // w_en implies any pending word is being taken this edge, so out_valid
  // simply follows whether a new word completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pack      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s3_v && w_word_done;
      if (r_s3_v) begin
        if (w_word_done) begin
          r_out_data  <= w_pack_next;
          r_out_bytes <= {1'b0, r_idx} + 3'd1;
          r_pack      <= '0;
          r_idx       <= '0;
        end else begin
          r_pack <= w_pack_next;
          r_idx  <= r_idx + 2'd1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bytes = r_out_bytes;
  assign busy      = r_s1_v || r_s2_v || r_s3_v || (r_idx != 2'd0) || r_out_valid;

`ifdef CFU_REQUANT_SAT_STATS_EN
  logic             r_s3_sat;
  logic [CNT_W-1:0] r_sat_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s3_sat <= 1'b0;
    end else if (w_en) begin
      r_s3_sat <= w_lo || w_hi;
    end
  end

  // Counted when the element lands in the pack buffer; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_cnt <= '0;
    end else if (cfg_valid && (cfg_addr == CFG_CLR)) begin
      r_sat_cnt <= '0;
    end else if (w_en && r_s3_v && r_s3_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign sat_count = r_sat_cnt;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_cfu_requant_packer.sv
// Self-checking bench for cfu_requant_packer: a requantisation/packing model
// predicts every output word; literal expectations pin the model.
module tb_cfu_requant_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        busy;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  cfu_requant_packer #(.PACK(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .busy(busy), .sat_count(sat_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model configuration
  int m_bias  = 0;
  int m_mult  = 32'h7FFF_FFFF;
  int m_shift = 0;
  int m_off   = 0;
  int m_min   = -128;
  int m_max   = 127;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
  } word_t;

  logic [7:0] pend[$];
  word_t      exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Requantise one accumulator with plain integer arithmetic
  function automatic logic [7:0] mreq(input logic [31:0] acc);
    int     x, high, y, v, res, r;
    longint ab, nudge, h, p, fl, rem, thr;
    x = int'(acc) + m_bias;
    if (m_shift > 0) x = x << m_shift;
    if (x == int'(32'h8000_0000) && m_mult == int'(32'h8000_0000)) begin
      high = 32'h7FFF_FFFF;
    end else begin
      ab    = longint'(x) * longint'(m_mult);
      nudge = (ab >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824);
      high  = int'((ab + nudge) / 64'sd2147483648);
    end
    r = (m_shift < 0) ? -m_shift : 0;
    p = 64'sd1 <<< r;
    h = high;
    if (h >= 0) fl = h / p;
    else        fl = -((-h + p - 1) / p);
    rem = h - fl * p;
    thr = (p - 1) / 2 + ((h < 0) ? 1 : 0);
    y = int'(fl + ((rem > thr) ? 1 : 0));
    v = y + m_off;
    if (m_min > m_max)   res = m_max;
    else if (v < m_min)  res = m_min;
    else if (v > m_max)  res = m_max;
    else                 res = v;
    return res[7:0];
  endfunction

  function automatic void model_push(input logic [31:0] d, input bit last);
    word_t w;
    pend.push_back(mreq(d));
    if (pend.size() == 4 || last) begin
      w.d = '0;
      for (int i = 0; i < pend.size(); i++) w.d[8*i +: 8] = pend[i];
      w.b = 3'(pend.size());
      exp_q.push_back(w);
      pend.delete();
    end
  endfunction

  // Single compare process against the model
  always @(negedge clk) begin
    if (reset) begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_word: out_valid=1 with data 0x%08h, required no word pending", out_data);
        end else begin
          check("word_data", out_data, exp_q[0].d);
          check("word_bytes", {29'b0, out_bytes}, {29'b0, exp_q[0].b});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    logic signed [5:0] s6;
    logic signed [7:0] s8;
    s6 = d[5:0];
    s8 = d[7:0];
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    case (a)
      3'd0: m_bias  = int'(d);
      3'd1: m_mult  = int'(d);
      3'd2: m_shift = s6;
      3'd3: m_off   = s8;
      3'd4: m_min   = s8;
      3'd5: m_max   = s8;
      default: ;
    endcase
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_defaults();
    cfg(3'd0, 32'h0);
    cfg(3'd1, 32'h7FFF_FFFF);
    cfg(3'd2, 32'h0);
    cfg(3'd3, 32'h0);
    cfg(3'd4, 32'h80);
    cfg(3'd5, 32'h7F);
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0, required 1 within 300 cycles");
    end else begin
      model_push(d, last);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Word must appear exactly 3 edges after the final transfer
  task automatic expect_word(input string nm, input logic [31:0] d, input logic [2:0] b);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i < 3) check({nm, "_early"}, {31'b0, out_valid}, 32'd0);
    end
    check({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({nm, "_data"}, out_data, d);
    check({nm, "_bytes"}, {29'b0, out_bytes}, {29'b0, b});
  endtask

  task automatic wait_idle(input string nm);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #3;
      if (!busy && exp_q.size() == 0) break;
    end
    check({nm, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({nm, "_idle_queue"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_bytes", {29'b0, out_bytes}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_sat_count", {16'b0, sat_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Pack order with reset-default config
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b0);
    send(32'd40, 1'b0);
    expect_word("pack", 32'h281E_140A, 3'd4);
    wait_idle("pack");

    // Rounding with multiplier 2^30 (-3 -> -1.5 -> -1 under the nudge rule)
    cfg(3'd1, 32'h4000_0000);
    send(32'd100, 1'b0);
    send(32'd3, 1'b0);
    send(-32'sd3, 1'b0);
    send(32'd1000, 1'b0);
    expect_word("round", 32'h7FFF_0232, 3'd4);
    wait_idle("round");

    // Negative shift, single-element words
    cfg(3'd1, 32'h7FFF_FFFF);
    cfg(3'd2, 32'h3E);
    send(-32'sd6, 1'b1);
    expect_word("negshift_a", 32'h0000_00FE, 3'd1);
    wait_idle("negshift_a");
    send(32'd6, 1'b1);
    expect_word("negshift_b", 32'h0000_0002, 3'd1);
    wait_idle("negshift_b");

    // Mixed config: bias, left shift, offset, narrow clamp, partial word
    cfg(3'd0, 32'd5);
    cfg(3'd2, 32'd1);
    cfg(3'd1, 32'h4000_0000);
    cfg(3'd3, 32'hFD);
    cfg(3'd4, 32'hF6);
    cfg(3'd5, 32'h0A);
    send(32'd7, 1'b0);
    send(-32'sd7, 1'b0);
    send(32'd0, 1'b0);
    send(32'd20, 1'b0);
    send(-32'sd30, 1'b0);
    send(32'd3, 1'b1);
    wait_idle("mixed");

    // Inverted clamp range resolves to act_max (-5)
    cfg(3'd0, 32'd0);
    cfg(3'd1, 32'h7FFF_FFFF);
    cfg(3'd2, 32'h3D);
    cfg(3'd3, 32'h0);
    cfg(3'd4, 32'h05);
    cfg(3'd5, 32'hFB);
    send(32'd12, 1'b0);
    send(-32'sd12, 1'b0);
    send(32'd100, 1'b1);
    expect_word("minmax", 32'h00FB_FBFB, 3'd3);
    wait_idle("minmax");

    // INT32_MIN * INT32_MIN saturates the high multiply
    cfg(3'd4, 32'h80);
    cfg(3'd5, 32'h7F);
    cfg(3'd2, 32'h0);
    cfg(3'd1, 32'h8000_0000);
    send(32'h8000_0000, 1'b1);
    expect_word("intmin", 32'h0000_007F, 3'd1);
    wait_idle("intmin");
    cfg(3'd2, 32'h21);
    send(32'h8000_0000, 1'b1);
    wait_idle("intmin_shr31");

    // Backpressure: 8 back-to-back inputs with the consumer stalled
    cfg_defaults();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(32'(i * 3), 1'b0);
      end
      begin
        repeat (15) @(posedge clk);
        #2;
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check("bp_busy", {31'b0, busy}, 32'd1);
        out_ready = 1'b1;
      end
    join
    wait_idle("bp");

    // Asynchronous reset mid-stream
    send(32'd50, 1'b0);
    send(32'd60, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    pend.delete();
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    send(-32'sd1, 1'b0);
    send(32'd2, 1'b0);
    send(-32'sd3, 1'b0);
    send(32'd4, 1'b0);
    wait_idle("arst");

    // Clamp event and the saturation counter
    cfg(3'd6, 32'h0);
    cfg(3'd3, 32'd100);
    send(32'd200, 1'b1);
    expect_word("sat_word", 32'h0000_007F, 3'd1);
`ifdef CFU_REQUANT_SAT_STATS_EN
    check("sat_count_inc", {16'b0, sat_count}, 32'd1);
    cfg(3'd6, 32'h0);
    check("sat_count_clr", {16'b0, sat_count}, 32'd0);
`else
    check("sat_count_tied", {16'b0, sat_count}, 32'd0);
`endif
    wait_idle("sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
